efuse_autoload: RTL and testbench
=================================

# efuse_autoload

Boot-time shadow loader that sits directly downstream of `efuse_read`. After reset it walks every read window (`read_sel` = 0 .. RSEL-1), pulses `read_start`, waits for `read_done` and captures each NR-bit `read_data` word into a 256-bit shadow register. Trim and config logic consume the shadow register. Software can request a reload. A per-window timeout flags a stuck read path.

## Interface
- `NR`, 64, bits returned per `efuse_read` transaction.
- `RSEL`, 256/NR, number of read windows; shadow width is NR*RSEL.
- `TIMEOUT`, 1024, maximum cycles to wait for `read_done` per window; must be ≥ 2.

- `clk`  in  1  single clock; same clock as `efuse_read`.
- `rst`  in  1  asynchronous, active-high reset.
- `reload_req`  in  1  single-cycle pulse that requests a full reload.
- `prog_busy`  in  1  efuse program path active; inhibits new `read_start`.
- `busy_read`  in  1  from `efuse_read`.
- `read_done`  in  1  single-cycle completion pulse from `efuse_read`.
- `read_data`  in  NR  word from `efuse_read`; valid when `read_done`=1.
- `read_start`  out  1  single-cycle start pulse to `efuse_read`.
- `read_sel`  out  $clog2(RSEL)  window index to `efuse_read`.
- `shadow_data`  out  NR*RSEL  captured efuse image.
- `shadow_valid`  out  1  image complete and error-free.
- `load_busy`  out  1  high from load start until the FIN cycle inclusive.
- `load_done`  out  1  single-cycle pulse at the end of each load (success or error).
- `load_err`  out  1  sticky timeout flag for the last load.

## Operation
- FSM states: IDLE, REQ, WAIT, FIN. All outputs are registered.
- Reset values: state=IDLE, `boot_pend`=1, `read_sel`=0, `read_start`=0, `shadow_data`=0, `shadow_valid`=0, `load_busy`=0, `load_done`=0, `load_err`=0, timer=0.
- IDLE → REQ when `boot_pend`=1 or `reload_req`=1. On this transition:
  - `boot_pend`←0, `read_sel`←0, `shadow_valid`←0, `load_err`←0, `load_busy`←1.
- REQ → WAIT when `busy_read`=0 and `prog_busy`=0. On that edge `read_start`←1 for exactly one cycle and timer←0. Otherwise stay in REQ; there is no timeout in REQ.
- WAIT:
  - If `read_done`=1: `shadow_data[read_sel*NR +: NR]`←`read_data`. If `read_sel`=RSEL-1, go to FIN. Otherwise `read_sel`←`read_sel`+1 and go to REQ.
  - Else if timer = TIMEOUT-1: `load_err`←1 and go to FIN. The current slice is not written.
  - Else timer←timer+1. Timer width is $clog2(TIMEOUT); it never wraps because it exits at TIMEOUT-1.
- FIN: `load_done`=1 for this one cycle, then go to IDLE. On exit, `load_busy`←0 and `shadow_valid`←~`load_err`.
- `read_done` is ignored outside WAIT.
- `reload_req` is ignored outside IDLE; it is not queued.
- Simultaneous `reload_req` and `boot_pend` in IDLE start one load only.
- Slices not rewritten during a load keep their previous value. `shadow_valid` qualifies the whole image.
- `read_sel` holds its value in IDLE and FIN.
- Reset mid-load aborts immediately: all state returns to reset values, and a fresh boot load starts after reset release.

## Timing
- With `rst` released before edge 0:
  - Edge 1: IDLE → REQ.
  - Edge 2: REQ → WAIT; `read_start` high during cycle 2–3.
- `read_data` is captured on the edge that samples `read_done`=1. The slice is visible on `shadow_data` the following cycle.
- Per-window overhead beyond the `efuse_read` latency is 1 cycle (WAIT → REQ) + 1 cycle (REQ → WAIT), with free busies.
- `load_done` and the rising edge of `shadow_valid` are one cycle apart: `shadow_valid` rises on the edge that ends the FIN cycle.
- Timeout: `load_err` rises exactly TIMEOUT cycles after `read_start` was asserted, if no `read_done` arrives.

## Test plan
- Boot load, `efuse_read` model returning 64'hA5A5_0000_0000_000n after 20 cycles for window n -> 4 `read_start` pulses with `read_sel` 0,1,2,3; `shadow_data`[255:192]=…0003, [63:0]=…0000; one `load_done`; `shadow_valid`=1; `load_err`=0.
- `prog_busy` held high for 50 cycles at boot -> no `read_start` until `prog_busy` falls; `read_start` appears 1 cycle after the REQ edge that samples `prog_busy`=0.
- Model never returns `read_done` on window 2 -> `load_err`=1 exactly TIMEOUT cycles after the third `read_start`; `load_done` pulses; `shadow_valid`=0; slices 0–1 written, slices 2–3 unchanged.
- Load done, then `reload_req` with new data 64'hFFFF… -> `shadow_valid` drops the cycle after `reload_req`; all slices = 64'hFFFF…; `shadow_valid`=1 at the end.
- `reload_req` pulsed while in WAIT -> ignored; only 4 `read_start` pulses total; a stray `read_done` while in IDLE does not change `shadow_data`.
- `rst` asserted mid-window 1 -> all outputs at reset values; on release, a new boot load starts from `read_sel`=0.

Source files
------------

// File: rtl/efuse_autoload.sv
// Boot-time shadow loader: walks every efuse_read window after reset (or on
// request) and assembles the returned words into one shadow image.
module efuse_autoload #(
  parameter int unsigned NR      = 64,
  parameter int unsigned RSEL    = 256 / NR,
  parameter int unsigned TIMEOUT = 1024,
  localparam int unsigned SELW   = (RSEL > 1) ? $clog2(RSEL) : 1,
  localparam int unsigned TW     = $clog2(TIMEOUT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 reload_req,
  input  logic                 prog_busy,
  input  logic                 busy_read,
  input  logic                 read_done,
  input  logic [NR-1:0]        read_data,
  output logic                 read_start,
  output logic [SELW-1:0]      read_sel,
  output logic [NR*RSEL-1:0]   shadow_data,
  output logic                 shadow_valid,
  output logic                 load_busy,
  output logic                 load_done,
  output logic                 load_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_FIN  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic               boot_pend_q, boot_pend_d;
  logic [SELW-1:0]    sel_q, sel_d;
  logic               start_q, start_d;
  logic [NR*RSEL-1:0] shadow_q, shadow_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [TW-1:0]      timer_q, timer_d;

  always_comb begin
    state_d     = state_q;
    boot_pend_d = boot_pend_q;
    sel_d       = sel_q;
    start_d     = 1'b0;
    shadow_d    = shadow_q;
    valid_d     = valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    timer_d     = timer_q;

    case (state_q)
      ST_IDLE: begin
        // A pending boot load and a reload request in the same cycle merge
        // into a single load.
        if (boot_pend_q || reload_req) begin
          state_d     = ST_REQ;
          boot_pend_d = 1'b0;
          sel_d       = '0;
          valid_d     = 1'b0;
          err_d       = 1'b0;
          busy_d      = 1'b1;
        end
      end

      ST_REQ: begin
        if (!busy_read && !prog_busy) begin
          state_d = ST_WAIT;
          start_d = 1'b1;
          timer_d = '0;
        end
      end

      ST_WAIT: begin
        if (read_done) begin
          for (int unsigned i = 0; i < RSEL; i++) begin
            if (sel_q == SELW'(i)) shadow_d[i*NR +: NR] = read_data;
          end
          if (sel_q == SELW'(RSEL - 1)) begin
            state_d = ST_FIN;
            done_d  = 1'b1;
          end else begin
            sel_d   = sel_q + SELW'(1);
            state_d = ST_REQ;
          end
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_FIN;
          done_d  = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      ST_FIN: begin
        // load_done is already high this cycle; the image is qualified on exit.
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        valid_d = ~err_q;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      boot_pend_q <= 1'b1;
      sel_q       <= '0;
      start_q     <= 1'b0;
      shadow_q    <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      boot_pend_q <= boot_pend_d;
      sel_q       <= sel_d;
      start_q     <= start_d;
      shadow_q    <= shadow_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      timer_q     <= timer_d;
    end
  end

  assign read_start   = start_q;
  assign read_sel     = sel_q;
  assign shadow_data  = shadow_q;
  assign shadow_valid = valid_q;
  assign load_busy    = busy_q;
  assign load_done    = done_q;
  assign load_err     = err_q;

endmodule

// File: tb/tb_efuse_autoload.sv
// Bench for efuse_autoload: an efuse_read model plus a scoreboard of the words
// it delivered per window, checked scenario by scenario.
module tb_efuse_autoload;

  localparam int TO = 1024;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         reload_req = 1'b0;
  logic         prog_busy = 1'b0;
  logic         busy_read = 1'b0;
  logic         m_done = 1'b0;
  logic         s_done = 1'b0;
  logic [63:0]  m_data = '0;
  logic [63:0]  s_data = '0;
  logic         read_done;
  logic [63:0]  read_data;
  logic         read_start;
  logic [1:0]   read_sel;
  logic [255:0] shadow_data;
  logic         shadow_valid;
  logic         load_busy;
  logic         load_done;
  logic         load_err;

  assign read_done = m_done | s_done;
  assign read_data = s_done ? s_data : m_data;

  efuse_autoload #(.NR(64), .RSEL(4), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .reload_req(reload_req), .prog_busy(prog_busy),
    .busy_read(busy_read), .read_done(read_done), .read_data(read_data),
    .read_start(read_start), .read_sel(read_sel), .shadow_data(shadow_data),
    .shadow_valid(shadow_valid), .load_busy(load_busy), .load_done(load_done),
    .load_err(load_err)
  );

  initial forever #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // efuse_read model state and scoreboard
  int          lat_min = 20, lat_max = 20;
  int          stuck = -1;
  int          dmode = 0;
  bit          rand_pb = 1'b0;
  int          starts = 0;
  int          sels[$];
  int unsigned start_cyc[$];
  int          pb_viol = 0;
  int          done_pulses = 0;
  logic [63:0] exp_sl [4];
  bit          pending = 1'b0;
  int          cnt = 0;
  int          cur_sel = 0;
  logic [63:0] pend_data = '0;
  int unsigned cyc = 0;
  logic        pb_edge = 1'b0;

  function automatic logic [63:0] gen(input int s);
    case (dmode)
      0:       return {16'hA5A5, 44'h0, 4'(s)};
      1:       return '1;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  function automatic logic [255:0] exp_img();
    return {exp_sl[3], exp_sl[2], exp_sl[1], exp_sl[0]};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
    pb_edge = prog_busy;
  end

  initial forever begin
    @(negedge clk);
    m_done = 1'b0;
    if (rst) begin
      pending   = 1'b0;
      busy_read = 1'b0;
    end else begin
      if (pending) begin
        if (cnt == 0) begin
          m_done           = 1'b1;
          m_data           = pend_data;
          exp_sl[cur_sel]  = pend_data;
          pending          = 1'b0;
          busy_read        = 1'b0;
        end else cnt--;
      end
      if (read_start) begin
        starts++;
        sels.push_back(int'(read_sel));
        start_cyc.push_back(cyc);
        if (pb_edge) pb_viol++;
        if (int'(read_sel) != stuck) begin
          pending   = 1'b1;
          busy_read = 1'b1;
          cnt       = int'($urandom_range(lat_max, lat_min)) - 1;
          cur_sel   = int'(read_sel);
          pend_data = gen(cur_sel);
        end
      end
      if (load_done) done_pulses++;
      if (rand_pb) prog_busy = ($urandom_range(2, 0) == 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1);
  end

  task automatic clear_model();
    starts = 0;
    sels.delete();
    start_cyc.delete();
    pb_viol = 0;
    done_pulses = 0;
  endtask

  task automatic do_reset(input bit hold_pb);
    @(negedge clk);
    rst = 1'b1;
    reload_req = 1'b0;
    prog_busy = hold_pb;
    #1;
    pending = 1'b0;
    busy_read = 1'b0;
    m_done = 1'b0;
    s_done = 1'b0;
    for (int i = 0; i < 4; i++) exp_sl[i] = '0;
    clear_model();
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_reload();
    reload_req = 1'b1;
    @(negedge clk);
    reload_req = 1'b0;
  endtask

  task automatic wait_load(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (load_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic bit sels_ok(input int n);
    if (sels.size() != n) return 1'b0;
    for (int i = 0; i < n; i++) if (sels[i] != i) return 1'b0;
    return 1'b1;
  endfunction

  task automatic test_reset();
    do_reset(1'b0);
    n_cmp++; if (read_start !== 1'b0) begin n_bad++; $display("FAIL reset_start: got %b want 0", read_start); end
    n_cmp++; if (read_sel !== 2'd0) begin n_bad++; $display("FAIL reset_sel: got %0d want 0", read_sel); end
    n_cmp++; if (shadow_data !== 256'd0) begin n_bad++; $display("FAIL reset_shadow: got %h want 0", shadow_data); end
    n_cmp++; if ({shadow_valid, load_busy, load_done, load_err} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_flags: got %b want 0000", {shadow_valid, load_busy, load_done, load_err}); end
  endtask

  task automatic test_boot();
    bit ok;
    dmode = 0; lat_min = 20; lat_max = 20; stuck = -1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if ({load_busy, read_start} !== 2'b10) begin
      n_bad++; $display("FAIL boot_edge1: got busy,start=%b want 10", {load_busy, read_start}); end
    @(negedge clk);
    n_cmp++; if ({read_start, read_sel} !== 3'b100) begin
      n_bad++; $display("FAIL boot_edge2: got start=%b sel=%0d want 1,0", read_start, read_sel); end
    wait_load(400, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL boot_timeout: got no load_done want load_done"); end
    n_cmp++; if ({load_busy, shadow_valid} !== 2'b10) begin
      n_bad++; $display("FAIL boot_fin: got busy,valid=%b want 10", {load_busy, shadow_valid}); end
    @(negedge clk);
    n_cmp++; if ({shadow_valid, load_busy, load_err, load_done} !== 4'b1000) begin
      n_bad++; $display("FAIL boot_end_flags: got %b want 1000", {shadow_valid, load_busy, load_err, load_done}); end
    n_cmp++; if (starts != 4 || !sels_ok(4)) begin
      n_bad++; $display("FAIL boot_sels: got %0d starts want 4 in order 0..3", starts); end
    n_cmp++; if (done_pulses != 1) begin n_bad++; $display("FAIL boot_done_count: got %0d want 1", done_pulses); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (start_cyc.size() == 4 && int'(start_cyc[i+1] - start_cyc[i]) != 22) begin
        n_bad++; $display("FAIL boot_spacing%0d: got %0d want 22", i, int'(start_cyc[i+1] - start_cyc[i])); end
    end
    n_cmp++; if (shadow_data[255:192] !== 64'hA5A5_0000_0000_0003 || shadow_data[63:0] !== 64'hA5A5_0000_0000_0000) begin
      n_bad++; $display("FAIL boot_slices: got %h / %h want a5a5..0003 / a5a5..0000", shadow_data[255:192], shadow_data[63:0]); end
    n_cmp++; if (shadow_data !== exp_img()) begin
      n_bad++; $display("FAIL boot_image: got %h want %h", shadow_data, exp_img()); end
  endtask

  task automatic test_prog_busy();
    bit ok;
    do_reset(1'b1);
    dmode = 0; lat_min = 20; lat_max = 20; stuck = -1;
    rst = 1'b0;
    repeat (50) @(negedge clk);
    n_cmp++; if (starts != 0 || load_busy !== 1'b1) begin
      n_bad++; $display("FAIL pbusy_hold: got starts=%0d busy=%b want 0,1", starts, load_busy); end
    prog_busy = 1'b0;
    @(negedge clk);
    n_cmp++; if (read_start !== 1'b1) begin n_bad++; $display("FAIL pbusy_release: got start=%b want 1", read_start); end
    wait_load(400, ok);
    @(negedge clk);
    n_cmp++; if (!ok || shadow_valid !== 1'b1 || shadow_data !== exp_img()) begin
      n_bad++; $display("FAIL pbusy_load: got ok=%b valid=%b img=%h want 1,1,%h", ok, shadow_valid, shadow_data, exp_img()); end
  endtask

  task automatic test_reload_ffff();
    bit ok;
    dmode = 1; lat_min = 3; lat_max = 15; stuck = -1;
    clear_model();
    n_cmp++; if (shadow_valid !== 1'b1) begin n_bad++; $display("FAIL reload_pre_valid: got %b want 1", shadow_valid); end
    pulse_reload();
    n_cmp++; if ({shadow_valid, load_busy} !== 2'b01) begin
      n_bad++; $display("FAIL reload_drop: got valid,busy=%b want 01", {shadow_valid, load_busy}); end
    wait_load(400, ok);
    @(negedge clk);
    n_cmp++; if (!ok || shadow_data !== '1 || shadow_valid !== 1'b1 || starts != 4) begin
      n_bad++; $display("FAIL reload_ffff: got ok=%b img=%h valid=%b starts=%0d want 1,all ones,1,4", ok, shadow_data, shadow_valid, starts); end
  endtask

  task automatic test_timeout();
    bit ok;
    int unsigned err_cyc;
    dmode = 0; lat_min = 20; lat_max = 20; stuck = -1;
    clear_model();
    pulse_reload();
    wait_load(400, ok);
    @(negedge clk);
    dmode = 2; lat_min = 1; lat_max = 30; stuck = 2;
    clear_model();
    pulse_reload();
    wait_load(3 * 40 + TO + 50, ok);
    err_cyc = cyc;
    n_cmp++; if (!ok || load_err !== 1'b1) begin
      n_bad++; $display("FAIL timeout_flag: got ok=%b err=%b want 1,1", ok, load_err); end
    n_cmp++; if (starts != 3 || int'(err_cyc - start_cyc[2]) != TO) begin
      n_bad++; $display("FAIL timeout_latency: got starts=%0d delta=%0d want 3,%0d", starts, int'(err_cyc - start_cyc[starts-1]), TO); end
    @(negedge clk);
    n_cmp++; if ({shadow_valid, load_busy, load_err} !== 3'b001 || done_pulses != 1) begin
      n_bad++; $display("FAIL timeout_end: got valid,busy,err=%b done=%0d want 001,1", {shadow_valid, load_busy, load_err}, done_pulses); end
    n_cmp++; if (shadow_data !== exp_img() || shadow_data[191:128] !== 64'hA5A5_0000_0000_0002) begin
      n_bad++; $display("FAIL timeout_image: got %h want %h", shadow_data, exp_img()); end
    stuck = -1;
  endtask

  task automatic test_reload_in_wait();
    bit ok, seen;
    int busy_seen;
    dmode = 2; lat_min = 5; lat_max = 25; stuck = -1;
    clear_model();
    pulse_reload();
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (read_start) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL wait_start: got no read_start want read_start"); end
    pulse_reload();
    wait_load(400, ok);
    busy_seen = 0;
    repeat (10) begin @(negedge clk); if (load_busy) busy_seen++; end
    n_cmp++; if (!ok || starts != 4 || busy_seen != 0) begin
      n_bad++; $display("FAIL wait_ignore: got ok=%b starts=%0d busy_cycles=%0d want 1,4,0", ok, starts, busy_seen); end
    n_cmp++; if (shadow_valid !== 1'b1 || shadow_data !== exp_img()) begin
      n_bad++; $display("FAIL wait_image: got valid=%b %h want 1,%h", shadow_valid, shadow_data, exp_img()); end
    s_data = {$urandom, $urandom};
    s_done = 1'b1;
    @(negedge clk);
    s_done = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (shadow_data !== exp_img() || starts != 4) begin
      n_bad++; $display("FAIL stray_done: got %h starts=%0d want %h,4", shadow_data, starts, exp_img()); end
  endtask

  task automatic test_random();
    bit ok;
    rand_pb = 1'b1;
    for (int it = 0; it < 4; it++) begin
      dmode = 2; lat_min = 1; lat_max = 12; stuck = -1;
      clear_model();
      pulse_reload();
      wait_load(600, ok);
      @(negedge clk);
      n_cmp++; if (!ok || starts != 4 || !sels_ok(4) || pb_viol != 0) begin
        n_bad++; $display("FAIL rand%0d_seq: got ok=%b starts=%0d pb_viol=%0d want 1,4,0", it, ok, starts, pb_viol); end
      n_cmp++; if (shadow_data !== exp_img() || {shadow_valid, load_err} !== 2'b10) begin
        n_bad++; $display("FAIL rand%0d_image: got %h valid,err=%b want %h,10", it, shadow_data, {shadow_valid, load_err}, exp_img()); end
      repeat (3) @(negedge clk);
    end
    rand_pb = 1'b0;
    prog_busy = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok;
    dmode = 1; lat_min = 20; lat_max = 20; stuck = -1;
    clear_model();
    pulse_reload();
    for (int i = 0; i < 200 && starts < 2; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    n_cmp++; if (starts != 2 || read_sel !== 2'd1) begin
      n_bad++; $display("FAIL mid_pre: got starts=%0d sel=%0d want 2,1", starts, read_sel); end
    rst = 1'b1;
    #1;
    pending = 1'b0; busy_read = 1'b0; m_done = 1'b0;
    for (int i = 0; i < 4; i++) exp_sl[i] = '0;
    n_cmp++; if ({read_start, read_sel, shadow_valid, load_busy, load_done, load_err} !== 7'd0 || shadow_data !== 256'd0) begin
      n_bad++; $display("FAIL mid_reset: got start=%b sel=%0d v/b/d/e=%b img=%h want all zero", read_start, read_sel,
                        {shadow_valid, load_busy, load_done, load_err}, shadow_data); end
    @(negedge clk);
    dmode = 0;
    clear_model();
    rst = 1'b0;
    wait_load(400, ok);
    @(negedge clk);
    n_cmp++; if (!ok || !sels_ok(4) || shadow_valid !== 1'b1 || shadow_data !== exp_img()
                 || shadow_data[127:64] !== 64'hA5A5_0000_0000_0001) begin
      n_bad++; $display("FAIL mid_reboot: got ok=%b starts=%0d valid=%b img=%h want 1,4,1,%h", ok, starts, shadow_valid, shadow_data, exp_img()); end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) exp_sl[i] = '0;
    test_reset();
    test_boot();
    test_prog_busy();
    test_reload_ffff();
    test_timeout();
    test_reload_in_wait();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
